// File: rtl/fp16_divider_pkg.sv
// Shared fp16 field widths, special encodings, operand-class flags and divider FSM states.
package fp16_divider_pkg;

    localparam int          FP16_EXP_W  = 5;
    localparam int          FP16_FRAC_W = 10;
    localparam int          FP16_BIAS   = 15;
    localparam logic [15:0] FP16_INF    = 16'h7C00;
    localparam logic [15:0] FP16_QNAN   = 16'h7E00;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DIV   = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp16_class_t;

endpackage

// File: rtl/fp16_classify.sv
// Operand class decode for fp16 magnitudes; subnormals count as zero.
module fp16_classify
    import fp16_divider_pkg::*;
(
    input  logic [14:0]  x_i,
    output fp16_class_t  cls_o
);

    logic [FP16_EXP_W-1:0]  exp_f;
    logic [FP16_FRAC_W-1:0] frac_f;

    assign exp_f  = x_i[14:10];
    assign frac_f = x_i[9:0];

    always_comb begin
        cls_o.zero = (exp_f == '0);
        cls_o.inf  = (exp_f == '1) && (frac_f == '0);
        cls_o.nan  = (exp_f == '1) && (frac_f != '0);
    end

endmodule

// File: rtl/fp16_divider.sv
// Iterative fp16 divider: restoring division one quotient bit per clock, RNE rounding,
// flush-to-zero on underflow, fixed 14-cycle latency for every operand class.
module fp16_divider
    import fp16_divider_pkg::*;
#(
    parameter int          QBITS   = 13,
    parameter logic [15:0] NAN_VAL = FP16_QNAN
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] out
);

    fp16_class_t cls_a, cls_b;

    fp16_classify u_cls_a (.x_i(A[14:0]), .cls_o(cls_a));
    fp16_classify u_cls_b (.x_i(B[14:0]), .cls_o(cls_b));

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [11:0]       rem_q, rem_d;
    logic [10:0]       div_q, div_d;
    logic [QBITS-1:0]  q_q, q_d;
    logic              sign_q, sign_d;
    logic signed [6:0] expd_q, expd_d;
    fp16_class_t       ca_q, ca_d, cb_q, cb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       out_q, out_d;

    // Normalise, round and pack from the finished quotient and final remainder
    logic [9:0]        mant;
    logic              guard, sticky, inc;
    logic [10:0]       mant_r;
    logic signed [6:0] exp_n, exp_r;
    logic [15:0]       res;

    always_comb begin
        if (q_q[QBITS-1]) begin
            mant   = q_q[QBITS-2 -: 10];
            guard  = q_q[1];
            sticky = q_q[0] | (rem_q != '0);
            exp_n  = expd_q + $signed(7'(FP16_BIAS));
        end else begin
            mant   = q_q[QBITS-3 -: 10];
            guard  = q_q[0];
            sticky = (rem_q != '0);
            exp_n  = expd_q + $signed(7'(FP16_BIAS - 1));
        end
        inc    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {10'd0, inc};
        exp_r  = exp_n + $signed({6'd0, mant_r[10]});

        if (ca_q.nan || cb_q.nan)
            res = NAN_VAL;
        else if ((ca_q.zero && cb_q.zero) || (ca_q.inf && cb_q.inf))
            res = NAN_VAL;
        else if (ca_q.inf || cb_q.zero)
            res = {sign_q, FP16_INF[14:0]};
        else if (ca_q.zero || cb_q.inf)
            res = {sign_q, 15'h0};
        else if (exp_r >= 7'sd31)
            res = {sign_q, FP16_INF[14:0]};
        else if (exp_r <= 7'sd0)
            res = {sign_q, 15'h0};
        else
            res = {sign_q, exp_r[4:0], mant_r[9:0]};
    end

    logic        ge;
    logic [11:0] rem_sub;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        div_d   = div_q;
        q_d     = q_q;
        sign_d  = sign_q;
        expd_d  = expd_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        ge      = (rem_q >= {1'b0, div_q});
        rem_sub = ge ? (rem_q - {1'b0, div_q}) : rem_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = A[15] ^ B[15];
                    expd_d  = $signed({2'b00, A[14:10]}) - $signed({2'b00, B[14:10]});
                    ca_d    = cls_a;
                    cb_d    = cls_b;
                    rem_d   = {2'b01, A[9:0]};
                    div_d   = {1'b1, B[9:0]};
                    q_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = DIV;
                end
            end
            DIV: begin
                // rem < div after a subtract, so the shift never loses bit 11
                q_d   = {q_q[QBITS-2:0], ge};
                rem_d = {rem_sub[10:0], 1'b0};
                if (cnt_q == 4'(QBITS - 1)) begin
                    cnt_d   = '0;
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ROUND: begin
                out_d   = res;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            sign_q  <= 1'b0;
            expd_q  <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            q_q     <= q_d;
            sign_q  <= sign_d;
            expd_q  <= expd_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_fp16_divider.sv
// Scoreboard bench for fp16_divider: expected quotients queued at launch, compared at done.
module tb_fp16_divider;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [15:0] A, B;
    logic        busy, done;
    logic [15:0] out;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [15:0] sb[$];

    fp16_divider dut (
        .CLK(CLK), .RESET(RESET), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .out(out)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (done === 1'b1) done_cnt++;

    task automatic launch(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] expv, input bit push);
        @(negedge CLK);
        A = a; B = b; start = 1'b1;
        if (push) sb.push_back(expv);
    endtask

    // cyc counts edges after the accepting edge; bcnt counts busy-high samples incl. that edge
    task automatic run_until_done(output int cyc, output int bcnt);
        cyc = -1; bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            start = 1'b0;
            cyc++;
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1; start = 1'b0; A = '0; B = '0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b out=%h want 0 0 0000", busy, done, out);
        end
        #20;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_basic;
        int cyc, bcnt;
        logic [15:0] e;
        launch(16'h4000, 16'h3C00, 16'h4000, 1'b1);
        run_until_done(cyc, bcnt);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL basic_timeout done=%b want 1", done);
        end else begin
            e = sb.pop_front();
            checks++;
            if (out !== e) begin errors++; $display("FAIL basic_out got %h want %h", out, e); end
        end
        checks++;
        if (cyc != 14) begin errors++; $display("FAIL basic_latency got %0d want 14", cyc); end
        checks++;
        if (bcnt != 14) begin errors++; $display("FAIL basic_busy_edges got %0d want 14", bcnt); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int cyc, bcnt;
        logic [15:0] e;
        launch(16'h3C00, 16'h4200, 16'h3555, 1'b1);
        run_until_done(cyc, bcnt);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL b2b_first_timeout done=%b want 1", done);
        end else begin
            e = sb.pop_front();
            checks++;
            if (out !== e) begin errors++; $display("FAIL b2b_first_out got %h want %h", out, e); end
        end
        // second start raised inside the done cycle
        A = 16'h4200; B = 16'h4000; start = 1'b1; sb.push_back(16'h3E00);
        run_until_done(cyc, bcnt);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL b2b_second_timeout done=%b want 1", done);
        end else begin
            e = sb.pop_front();
            checks++;
            if (out !== e) begin errors++; $display("FAIL b2b_second_out got %h want %h", out, e); end
        end
        checks++;
        if (cyc != 14) begin errors++; $display("FAIL b2b_latency got %0d want 14", cyc); end
        launch(16'hC000, 16'h4000, 16'hBC00, 1'b1);
        run_until_done(cyc, bcnt);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL neg_timeout done=%b want 1", done);
        end else begin
            e = sb.pop_front();
            checks++;
            if (out !== e) begin errors++; $display("FAIL neg_out got %h want %h", out, e); end
        end
    endtask

    task automatic test_specials;
        logic [15:0] ta[9] = '{16'h0000, 16'h528F, 16'h7C00, 16'h7C01, 16'h0000,
                               16'h528F, 16'hD28F, 16'h7BFF, 16'h0400};
        logic [15:0] tbv[9] = '{16'h0000, 16'h0000, 16'h7C00, 16'h528F, 16'h528F,
                                16'h7C00, 16'h0000, 16'h0400, 16'h7BFF};
        logic [15:0] te[9] = '{16'h7E00, 16'h7C00, 16'h7E00, 16'h7E00, 16'h0000,
                               16'h0000, 16'hFC00, 16'h7C00, 16'h0000};
        int cyc, bcnt;
        logic [15:0] e;
        for (int i = 0; i < 9; i++) begin
            launch(ta[i], tbv[i], te[i], 1'b1);
            run_until_done(cyc, bcnt);
            checks++;
            if (done !== 1'b1) begin
                errors++; $display("FAIL special_%0d_timeout done=%b want 1", i, done);
            end else begin
                e = sb.pop_front();
                checks++;
                if (out !== e)
                    begin errors++; $display("FAIL special_%0d %h/%h got %h want %h", i, ta[i], tbv[i], out, e); end
                checks++;
                if (cyc != 14)
                    begin errors++; $display("FAIL special_%0d_latency got %0d want 14", i, cyc); end
            end
        end
    endtask

    task automatic test_ignore_start;
        int cyc, bcnt, dc;
        logic [15:0] e;
        launch(16'h3C00, 16'h4200, 16'h3555, 1'b1);
        @(posedge CLK); #1; start = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        A = 16'h4000; B = 16'h3C00; start = 1'b1;
        @(posedge CLK); #1; start = 1'b0;
        dc = done_cnt;
        run_until_done(cyc, bcnt);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL ignore_timeout done=%b want 1", done);
        end else begin
            e = sb.pop_front();
            checks++;
            if (out !== e) begin errors++; $display("FAIL ignore_out got %h want %h", out, e); end
        end
        repeat (20) @(negedge CLK);
        checks++;
        if (done_cnt - dc != 1) begin errors++; $display("FAIL ignore_pulses got %0d want 1", done_cnt - dc); end
        checks++;
        if (out !== 16'h3555) begin errors++; $display("FAIL ignore_hold got %h want 3555", out); end
    endtask

    task automatic test_reset_midop;
        int cyc, bcnt, dc;
        logic [15:0] e;
        launch(16'h4200, 16'h4000, 16'h3E00, 1'b0);
        @(posedge CLK); #1; start = 1'b0;
        repeat (6) @(posedge CLK);
        #2; RESET = 1'b1; #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== 16'h0000) begin
            errors++;
            $display("FAIL midop_reset busy=%b done=%b out=%h want 0 0 0000", busy, done, out);
        end
        @(negedge CLK); RESET = 1'b0;
        dc = done_cnt;
        repeat (20) @(negedge CLK);
        checks++;
        if (done_cnt != dc) begin errors++; $display("FAIL midop_no_done got %0d pulses want 0", done_cnt - dc); end
        launch(16'h4000, 16'h3C00, 16'h4000, 1'b1);
        run_until_done(cyc, bcnt);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL after_reset_timeout done=%b want 1", done);
        end else begin
            e = sb.pop_front();
            checks++;
            if (out !== e) begin errors++; $display("FAIL after_reset_out got %h want %h", out, e); end
        end
        checks++;
        if (cyc != 14) begin errors++; $display("FAIL after_reset_latency got %0d want 14", cyc); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_specials;
        test_ignore_start;
        test_reset_midop;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
